// File: rtl/stream_lane_align.sv
// Lane realigner for wide AXI-Stream packets: drops the first cfg_first lanes of a packet,
// re-packs the remaining lanes across beat boundaries and drives per-lane tkeep on the last beat.
module stream_lane_align #(
    parameter int LANE_W = 64,
    parameter int LANES  = 24,
    parameter int OFS_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*LANE_W-1:0] s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [OFS_W-1:0]        cfg_first,
    input  logic [OFS_W-1:0]        cfg_last,
    output logic [LANES*LANE_W-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [LANES-1:0]        m_tkeep,
    output logic                    m_tlast,
    output logic                    err_cfg,
    output logic [CNT_W-1:0]        pkt_cnt
);

    localparam int               DW        = LANES * LANE_W;
    localparam logic [OFS_W:0]   LANES_EXT = (OFS_W + 1)'(LANES);
    localparam logic [OFS_W-1:0] LAST_LANE = OFS_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    h_q, h_d;
    logic [OFS_W-1:0] f_q, f_d;
    logic [OFS_W-1:0] l_q, l_d;
    logic [DW-1:0]    m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             m_tlast_q, m_tlast_d;
    logic [LANES-1:0] m_tkeep_q, m_tkeep_d;
    logic             err_cfg_q, err_cfg_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic             out_free;
    logic             accept;
    logic             first_bad;
    logic             last_bad;
    logic [OFS_W-1:0] first_eff;
    logic [OFS_W-1:0] last_eff;
    logic [OFS_W-1:0] f_cur;
    logic [OFS_W-1:0] l_cur;
    logic [31:0]      shr_amt;
    logic [31:0]      shl_amt;
    logic [DW-1:0]    shr_b;
    logic [DW-1:0]    shr_h;
    logic [DW-1:0]    shl_b;
    logic [LANES-1:0] keep_last;

    assign out_free = ~m_tvalid_q | m_tready;
    assign s_tready = out_free & (state_q != FLUSH) & ~rst;
    assign accept   = s_tvalid & s_tready;

    assign first_bad = {1'b0, cfg_first} >= LANES_EXT;
    assign last_bad  = {1'b0, cfg_last} >= LANES_EXT;
    assign first_eff = first_bad ? '0 : cfg_first;
    assign last_eff  = last_bad ? LAST_LANE : cfg_last;

    // The first beat of a packet is shifted with the config being sampled in the same cycle
    assign f_cur = (state_q == IDLE) ? first_eff : f_q;
    assign l_cur = (state_q == IDLE) ? last_eff : l_q;

    assign shr_amt = 32'(f_cur) * 32'(LANE_W);
    assign shl_amt = (32'(LANES) - 32'(f_cur)) * 32'(LANE_W);
    assign shr_b   = s_tdata >> shr_amt;
    assign shr_h   = h_q >> shr_amt;
    assign shl_b   = s_tdata << shl_amt;

    always_comb begin
        keep_last = '0;
        for (int i = 0; i < LANES; i++) begin
            keep_last[i] = (OFS_W'(i) <= l_cur);
        end
    end

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        f_d        = f_q;
        l_d        = l_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q & ~m_tready;
        err_cfg_d  = err_cfg_q;
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(m_tvalid_q & m_tready & m_tlast_q);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    f_d       = first_eff;
                    l_d       = last_eff;
                    err_cfg_d = err_cfg_q | first_bad | last_bad;
                    if (first_eff == '0) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = s_tdata;
                        m_tlast_d  = s_tlast;
                        m_tkeep_d  = s_tlast ? keep_last : '1;
                    end else if (s_tlast) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = shr_b;
                        m_tlast_d  = 1'b1;
                        m_tkeep_d  = keep_last;
                    end else begin
                        h_d     = s_tdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = shr_h | shl_b;
                    m_tlast_d  = 1'b0;
                    m_tkeep_d  = '1;
                    h_d        = s_tdata;
                    if (s_tlast) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Tail of the held beat; input is blocked for this one cycle
                if (out_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = shr_h;
                    m_tlast_d  = 1'b1;
                    m_tkeep_d  = keep_last;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            h_q        <= '0;
            f_q        <= '0;
            l_q        <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tkeep_q  <= '1;
            err_cfg_q  <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            f_q        <= f_d;
            l_q        <= l_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tkeep_q  <= m_tkeep_d;
            err_cfg_q  <= err_cfg_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = m_tlast_q;
    assign err_cfg  = err_cfg_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: doc/stream_lane_align.md
Name: stream_lane_align

Overview:
- Parametrised lane realigner for wide AXI-Stream packets. Each beat is LANES lanes of LANE_W bits.
- Drops the first cfg_first lanes of a packet and re-packs all following lanes contiguously across beat boundaries.
- Generates per-lane m_tkeep on the final beat from cfg_last.
- Sits between the systolic array output and the DMA write path, with full AXI-Stream backpressure and a registered output.

Parameters:
LANE_W, 64, bits per lane
LANES, 24, lanes per beat
OFS_W, 5, width of lane-index config ports; 2^OFS_W >= LANES required
CNT_W, 16, width of packet counter

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
s_tdata  in  LANES*LANE_W  input beat, lane i = bits [i*LANE_W +: LANE_W]
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tlast  in  1  last input beat of packet
cfg_first  in  OFS_W  lanes dropped from start of packet
cfg_last  in  OFS_W  index of last valid lane in final output beat
m_tdata  out  LANES*LANE_W  output beat
m_tvalid  out  1  output valid
m_tready  in  1  output ready
m_tkeep  out  LANES  per-lane keep
m_tlast  out  1  last output beat
err_cfg  out  1  sticky illegal-config flag
pkt_cnt  out  CNT_W  completed output packets, wraps modulo 2^CNT_W

Behaviour:
- Reset:
  - rst high forces state IDLE, m_tvalid=0, m_tlast=0, m_tkeep=all ones, m_tdata=0, hold register H=0, err_cfg=0, pkt_cnt=0, s_tready=0.
  - Asserting rst mid-packet discards H and any pending output beat. The first beat accepted after release starts a new packet.
- Output register and ready:
  - out_free = ~m_tvalid | m_tready.
  - Output register loads only when out_free.
  - m_tvalid stays high, and m_tdata/m_tkeep/m_tlast stay stable, until m_tready.
  - s_tready = out_free & (state != FLUSH) & ~rst.
  - Accept = s_tvalid & s_tready.
- Config sampling:
  - cfg_first and cfg_last are latched as F and L on the accepted first beat of a packet (state IDLE).
  - Changes mid-packet are ignored.
  - cfg_first >= LANES or cfg_last >= LANES: sets err_cfg; the offending value is treated as 0 (F) or LANES-1 (L).
- Shift notation:
  - SHR(x) = x >> (F*LANE_W).
  - SHL(x) = x << ((LANES-F)*LANE_W).
- State IDLE, on accept of beat B:
  - F==0: output B, m_tlast=s_tlast, remain IDLE (pass-through, 1-cycle latency).
  - F>0 and s_tlast: output SHR(B) as last beat, remain IDLE.
  - F>0 and not s_tlast: H=B, no output, go HOLD.
- State HOLD, on accept of B:
  - Output SHR(H)|SHL(B), m_tlast=0, H=B.
  - s_tlast: go FLUSH; else stay HOLD.
- State FLUSH:
  - s_tready=0.
  - When out_free: output SHR(H) with m_tlast=1, go IDLE.
- Beat count: N input beats produce exactly N output beats.
- m_tkeep:
  - All ones on non-last beats.
  - On the last beat, bits 0..L set and bits above L clear.
  - Pass-through mode uses the same rule.
- pkt_cnt increments on each m_tvalid & m_tready & m_tlast.
- Vacated lanes: lanes vacated by a shift on the final beat are zero-filled.
- Throughput: one beat per cycle sustained under continuous m_tready. One bubble on input per packet (the FLUSH cycle) when F>0.

Test Plan:
- Lane i of input beat k = {k[31:0], i[31:0]}; F=2, L=5, 3-beat packet, m_tready=1 -> 3 output beats:
  - beat0 lanes = b0:2..23, b1:0..1
  - beat1 lanes = b1:2..23, b2:0..1
  - beat2 lanes = b2:2..23, upper 2 lanes zero; tkeep=0x00003F, tlast=1
  - pkt_cnt=1
- F=0, L=23, 4-beat packet -> data unchanged, each output 1 cycle after accept, tkeep=0xFFFFFF on all beats, tlast on beat 3 only.
- Single-beat packet, F=23, L=0 -> one output, lane0 = input lane23, remaining lanes 0, tkeep=0x000001, tlast=1, state returns IDLE.
- F=3, 5-beat packet, m_tready toggling 1/0 every cycle and random s_tvalid gaps -> no beat lost or duplicated, outputs stable while stalled, s_tready=0 in FLUSH.
- cfg_first=30 -> err_cfg=1 and stays set, packet passes through as F=0. cfg_first changed mid-packet -> no effect on that packet.
- rst pulsed asynchronously (mid-cycle) while in HOLD with m_tvalid=1 -> m_tvalid=0 immediately. Next 2-beat packet with F=1 is realigned correctly with no residue from H. pkt_cnt=0 before it completes.
